cholesky_arbiter: RTL
=====================

Name: cholesky_arbiter

Overview:
- Shares one `cholesky` core between NUM_REQ filter stages, e.g. the sigma-point predict and update covariance paths.
- Arbitrates requests round-robin, latches the winning packed matrix and issues a single-cycle `A_valid` to the core.
- Waits for `L_valid` with a watchdog, then returns the factor to the granted requester over a valid/ready response handshake.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 480, packed matrix width: 15 x 32-bit lower-triangular elements, element 11 at bits [31:0], element 55 at [479:448].
- TIMEOUT, 4096, cycles to wait for `core_L_valid` before aborting; must be ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset, sampled on rising clk.
- clk_en  in  1  global clock enable; same signal drives the core's clk_en.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_A  in  NUM_REQ*DATA_W  per-requester packed A; requester i at [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot, combinational; asserted to the current winner.
- resp_valid  out  NUM_REQ  one-hot response valid.
- resp_ready  in  NUM_REQ  per-requester response accept.
- resp_L  out  DATA_W  registered factor, shared by all requesters.
- resp_err  out  1  qualifies resp_valid; 1 = watchdog timeout.
- core_A  out  DATA_W  to core A; held stable from ISSUE until return to IDLE.
- core_A_valid  out  1  to core A_valid; registered one-cycle pulse.
- core_L  in  DATA_W  from core L.
- core_L_valid  in  1  from core L_valid.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (rst==0 at posedge, regardless of clk_en):
  - state=IDLE, RR pointer=0 (requester 0 highest priority), wait counter=0.
  - All outputs 0; resp_L=0, core_A=0.
  - Core shares the reset event at top level.
- clk_en==0: all state, counters and registered outputs hold. req_ready is forced to 0, so no transfer occurs.
- FSM has states IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner g = first i with req_valid[i], scanning from pointer upward modulo NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle.
  - On transfer: latch req_A[g] into core_A, store g, go to ISSUE.
  - Next cycle core_A_valid=1. No transfer when no request is valid.
- ISSUE: exactly one cycle. core_A_valid=1, counter cleared, then go to WAIT.
- WAIT:
  - core_A_valid=0; counter increments each enabled cycle.
  - On core_L_valid: capture core_L into resp_L, set resp_err=0, resp_valid[g]=1, go to RESP.
  - Else when counter reaches TIMEOUT-1: set resp_L=0, resp_err=1, resp_valid[g]=1, go to RESP.
  - If core_L_valid coincides with the timeout cycle, the valid result wins (resp_err=0).
- RESP:
  - resp_valid[g], resp_L and resp_err are held until resp_ready[g]==1. resp_ready on other lines is ignored.
  - On accept: resp_valid=0, pointer=(g+1) mod NUM_REQ, go to IDLE.
  - The earliest next grant is the cycle after accept.
- core_L_valid outside WAIT is ignored. A single core_L_valid pulse, or the first cycle of a multi-cycle high, completes the job.
- Latency from req transfer to resp_valid is core latency + 2 cycles: 1 cycle to ISSUE, core latency from its A_valid, 1 capture cycle.
- Fairness: with every requester permanently valid, grants rotate 0,1,...,NUM_REQ-1. No requester waits more than NUM_REQ-1 jobs.
- req_valid deasserting while not granted is legal and drops the request silently. req_A is only sampled on transfer.
- Reset mid-job (any state): returns to IDLE immediately and clears outputs. The pending response is lost.

Test Plan:
- Single request: req_valid[0]=1 with A, stub core of latency 40 returning L=~A. Required:
  - req_ready[0] high the same cycle.
  - core_A_valid high exactly 1 cycle, one cycle after transfer.
  - resp_valid[0] rises 42 cycles after transfer with resp_L=~A and resp_err=0.
  - Held with resp_ready=0 for 10 cycles, stable throughout.
- Contention: req_valid=2'b11 continuously, each requester with distinct A. Grant order 0,1,0,1 over 4 jobs, each resp_L matching its own A, and resp_valid never on the wrong line.
- Timeout: TIMEOUT=16, stub core never asserts L_valid. Required:
  - resp_valid[g]=1 with resp_err=1 and resp_L=0 after 16 WAIT cycles.
  - After accept, busy=0 and the next request proceeds normally.
- Timeout tie: L_valid arrives in the final WAIT cycle. Required: resp_err=0 and resp_L=core_L.
- clk_en toggling: drive clk_en=0 for 5 cycles during ISSUE and during WAIT. Required:
  - core_A_valid stays high through the freeze.
  - The counter does not advance.
  - Total latency grows by exactly the disabled cycles.
- Reset mid-WAIT: pull rst=0 for 1 cycle. Required:
  - Next cycle busy=0, resp_valid=0, core_A_valid=0.
  - A late core_L_valid is ignored.
  - The pointer restarts at requester 0.

Source files
------------

// File: rtl/cholesky_arbiter.sv
// Round-robin front end that shares one cholesky core between NUM_REQ
// filter stages: grants a requester, issues its matrix to the core, waits
// for the factor under a watchdog and hands the result back with a
// valid/ready handshake.
module cholesky_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 480,
    parameter int TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_A,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [DATA_W-1:0]         resp_L,
    output logic                      resp_err,
    output logic [DATA_W-1:0]         core_A,
    output logic                      core_A_valid,
    input  logic [DATA_W-1:0]         core_L,
    input  logic                      core_L_valid,
    output logic                      busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   g_q, g_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  core_A_q, core_A_d;
    logic               core_A_valid_q, core_A_valid_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]  resp_L_q, resp_L_d;
    logic               resp_err_q, resp_err_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;

    // Winner: first valid requester scanning upward from the RR pointer.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = (int'(ptr_q) + k) % NUM_REQ;
            if (!win_found && req_valid[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

    // Grant is only offered in IDLE on an enabled cycle, so a frozen
    // arbiter never completes a transfer it cannot register.
    always_comb begin
        req_ready = '0;
        if (clk_en && state_q == S_IDLE && win_found)
            req_ready[win_idx] = 1'b1;
    end

    // Next-state and registered-output logic for the job FSM.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        g_d            = g_q;
        cnt_d          = cnt_q;
        core_A_d       = core_A_q;
        core_A_valid_d = 1'b0;
        resp_valid_d   = resp_valid_q;
        resp_L_d       = resp_L_q;
        resp_err_d     = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    core_A_d       = req_A[int'(win_idx)*DATA_W +: DATA_W];
                    g_d            = win_idx;
                    core_A_valid_d = 1'b1;
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the last watchdog cycle still wins.
                if (core_L_valid) begin
                    resp_L_d          = core_L;
                    resp_err_d        = 1'b0;
                    resp_valid_d      = '0;
                    resp_valid_d[g_q] = 1'b1;
                    state_d           = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    resp_L_d          = '0;
                    resp_err_d        = 1'b1;
                    resp_valid_d      = '0;
                    resp_valid_d[g_q] = 1'b1;
                    state_d           = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (resp_ready[g_q]) begin
                    resp_valid_d = '0;
                    ptr_d        = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + IDX_W'(1);
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register: synchronous reset overrides the clock enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            g_q            <= '0;
            cnt_q          <= '0;
            core_A_q       <= '0;
            core_A_valid_q <= 1'b0;
            resp_valid_q   <= '0;
            resp_L_q       <= '0;
            resp_err_q     <= 1'b0;
        end else if (clk_en) begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            g_q            <= g_d;
            cnt_q          <= cnt_d;
            core_A_q       <= core_A_d;
            core_A_valid_q <= core_A_valid_d;
            resp_valid_q   <= resp_valid_d;
            resp_L_q       <= resp_L_d;
            resp_err_q     <= resp_err_d;
        end
    end

    assign core_A       = core_A_q;
    assign core_A_valid = core_A_valid_q;
    assign resp_valid   = resp_valid_q;
    assign resp_L       = resp_L_q;
    assign resp_err     = resp_err_q;
    assign busy         = (state_q != S_IDLE);

endmodule
